// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache fill controller:
// field widths, FSM state encoding and fetch-address field extraction.
package icache_pkg;

  localparam int TAG_W       = 5;
  localparam int INDEX_W     = 7;
  localparam int WORD_W      = 3;
  localparam int BLOCK_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    UPDATE = 2'd2
  } fill_state_t;

  // Tag sits above the 128-block index
  function automatic logic [TAG_W-1:0] addr_tag(input logic [15:0] addr);
    return addr[15:11];
  endfunction

  // Block index selects one metadata entry and one data-array block
  function automatic logic [INDEX_W-1:0] addr_index(input logic [15:0] addr);
    return addr[10:4];
  endfunction

  // 16-bit word within the block; the byte bit below it is ignored
  function automatic logic [WORD_W-1:0] addr_word(input logic [15:0] addr);
    return addr[3:1];
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_meta_array.sv
// Valid/tag store for the direct-mapped cache: combinational read,
// one synchronous write port, valid bits cleared by synchronous reset.
module meta_array
  import icache_pkg::*;
#(
  parameter int ENTRIES = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];

  // Valid bits: cleared on reset, set when a fill installs an entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tags need no reset because an entry is only trusted while its valid bit is set
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction-cache controller: resolves hit/miss for each
// fetch, and on a miss stalls the front end, streams an 8-word block from
// memory into the external data array, then installs the tag.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int INDEX_BITS      = 7,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic [15:0]        fetch_addr,
  output logic               hit,
  output logic               stall,
  output logic               mem_rd,
  output logic [15:0]        mem_addr,
  input  logic               mem_data_valid,
  input  logic [15:0]        mem_data,
  output logic               data_we,
  output logic [INDEX_W-1:0] data_index,
  output logic [WORD_W-1:0]  data_word,
  output logic [15:0]        data_wdata,
  output logic               fill_done
);

  // The controller counts responses, never cycles, so memory latency only documents the system
  localparam logic [3:0] CNT_MAX  = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0] CNT_LAST = 4'(WORDS_PER_BLOCK - 1);

  fill_state_t        state_q, state_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0] miss_index_q, miss_index_d;
  logic [3:0]         req_cnt_q, req_cnt_d;
  logic [3:0]         rsp_cnt_q, rsp_cnt_d;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic               meta_valid;
  logic [TAG_W-1:0]   meta_tag;
  logic               meta_we;
  logic               miss;

  assign req_tag   = addr_tag(fetch_addr);
  assign req_index = addr_index(fetch_addr);

  meta_array #(
    .ENTRIES (1 << INDEX_BITS)
  ) u_meta (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (req_index),
    .rd_valid (meta_valid),
    .rd_tag   (meta_tag),
    .wr_en    (meta_we),
    .wr_index (miss_index_q),
    .wr_tag   (miss_tag_q)
  );

  // Fetches are only serviced in IDLE; a miss stalls in the same cycle it is seen
  assign hit        = (state_q == IDLE) & fetch_req & meta_valid & (meta_tag == req_tag);
  assign miss       = (state_q == IDLE) & fetch_req & ~hit;
  assign stall      = (state_q != IDLE) | miss;
  assign data_wdata = mem_data;

  // State, latched miss block and request/response counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      req_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      req_cnt_q    <= req_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
    end
  end

  // Next-state and outputs; requests and responses are independent so both can occur in one FILL cycle
  always_comb begin
    state_d      = state_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    req_cnt_d    = req_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    data_we      = 1'b0;
    data_index   = '0;
    data_word    = '0;
    meta_we      = 1'b0;
    fill_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss) begin
          miss_tag_d   = req_tag;
          miss_index_d = req_index;
          req_cnt_d    = '0;
          rsp_cnt_d    = '0;
          state_d      = FILL;
        end
      end

      FILL: begin
        if (req_cnt_q < CNT_MAX) begin
          mem_rd    = 1'b1;
          mem_addr  = {miss_tag_q, miss_index_q, req_cnt_q[WORD_W-1:0], 1'b0};
          req_cnt_d = req_cnt_q + 4'd1;
        end
        if (mem_data_valid && (rsp_cnt_q < CNT_MAX)) begin
          data_we    = 1'b1;
          data_index = miss_index_q;
          data_word  = rsp_cnt_q[WORD_W-1:0];
          rsp_cnt_d  = rsp_cnt_q + 4'd1;
          if (rsp_cnt_q == CNT_LAST) begin
            state_d = UPDATE;
          end
        end
      end

      UPDATE: begin
        meta_we   = 1'b1;
        fill_done = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
